scariv_ras_ckpt: RTL and testbench

//  Parametrised return-address stack for the fetch predictor, with checkpoint/restore for mispredict recovery.

---
 rtl/scariv_ras_ckpt_pkg.sv | 29 ++
 rtl/scariv_ras_ckpt.sv | 105 ++++++++++
 tb/tb_scariv_ras_ckpt.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/scariv_ras_ckpt_pkg.sv
// Shared definitions for the return-address stack: default sizing and the
// per-cycle operation decode used by the pointer/count next-state logic.
package scariv_ras_ckpt_pkg;

    localparam int RAS_ENTRY_SIZE = 16;
    localparam int RAS_VADDR_W    = 39;

    typedef enum logic [2:0] {
        RAS_OP_IDLE     = 3'd0,
        RAS_OP_PUSH     = 3'd1,
        RAS_OP_POP      = 3'd2,
        RAS_OP_PUSH_POP = 3'd3,
        RAS_OP_RESTORE  = 3'd4
    } ras_op_e;

    // Restore dominates; a push+pop on an empty stack degenerates to a plain push,
    // and a pop on an empty stack is dropped.
    function automatic ras_op_e ras_decode_op(input logic restore, input logic push,
                                              input logic pop, input logic empty);
        ras_op_e op;
        op = RAS_OP_IDLE;
        if (restore)           op = RAS_OP_RESTORE;
        else if (push && pop)  op = empty ? RAS_OP_PUSH : RAS_OP_PUSH_POP;
        else if (push)         op = RAS_OP_PUSH;
        else if (pop && !empty) op = RAS_OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/scariv_ras_ckpt.sv
// Circular return-address stack with a {ptr,cnt,top_vaddr} checkpoint that the
// fetch unit stores per branch and hands back for single-cycle flush recovery.
module scariv_ras_ckpt
    import scariv_ras_ckpt_pkg::*;
#(
    parameter int ENTRY_SIZE = RAS_ENTRY_SIZE,
    parameter int VADDR_W    = RAS_VADDR_W,
    localparam int PTR_W     = $clog2(ENTRY_SIZE),
    localparam int CKPT_W    = PTR_W + (PTR_W + 1) + VADDR_W
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push_valid,
    input  logic [VADDR_W-1:0] i_push_vaddr,
    input  logic               i_pop_valid,
    input  logic               i_restore_valid,
    input  logic [CKPT_W-1:0]  i_restore_ckpt,
    output logic               o_top_valid,
    output logic [VADDR_W-1:0] o_top_vaddr,
    output logic [CKPT_W-1:0]  o_ckpt
);

    typedef logic [PTR_W-1:0] ras_ptr_t;
    typedef logic [PTR_W:0]   ras_cnt_t;

    ras_ptr_t           ptr_q, ptr_d;
    ras_cnt_t           cnt_q, cnt_d;
    logic [VADDR_W-1:0] mem_q [ENTRY_SIZE];
    logic [VADDR_W-1:0] mem_d [ENTRY_SIZE];

    ras_ptr_t           rst_ptr;
    ras_cnt_t           rst_cnt;
    logic [VADDR_W-1:0] rst_top;
    ras_op_e            op;
    logic               wr_en;
    ras_ptr_t           wr_idx;
    logic [VADDR_W-1:0] wr_data;

    // Checkpoint layout, MSB first: {ptr, cnt, top_vaddr}.
    assign rst_ptr = i_restore_ckpt[CKPT_W-1 -: PTR_W];
    assign rst_cnt = i_restore_ckpt[VADDR_W +: PTR_W+1];
    assign rst_top = i_restore_ckpt[VADDR_W-1:0];

    assign op = ras_decode_op(i_restore_valid, i_push_valid, i_pop_valid, cnt_q == '0);

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = i_push_vaddr;
        case (op)
            RAS_OP_RESTORE: begin
                ptr_d   = rst_ptr;
                cnt_d   = rst_cnt;
                // Repairs the top entry that wrong-path pushes may have clobbered.
                wr_en   = (rst_cnt != '0);
                wr_idx  = rst_ptr;
                wr_data = rst_top;
            end
            RAS_OP_PUSH: begin
                ptr_d  = ptr_q + ras_ptr_t'(1);
                cnt_d  = (cnt_q == ras_cnt_t'(ENTRY_SIZE)) ? cnt_q : cnt_q + ras_cnt_t'(1);
                wr_en  = 1'b1;
                wr_idx = ptr_q + ras_ptr_t'(1);
            end
            RAS_OP_PUSH_POP: begin
                wr_en  = 1'b1;
                wr_idx = ptr_q;
            end
            RAS_OP_POP: begin
                ptr_d = ptr_q - ras_ptr_t'(1);
                cnt_d = cnt_q - ras_cnt_t'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en && !i_reset) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset; cnt gates its visibility.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_top_valid = (cnt_q != '0);
    assign o_top_vaddr = o_top_valid ? mem_q[ptr_q] : '0;
    assign o_ckpt      = {ptr_q, cnt_q, o_top_vaddr};

endmodule

// File: tb/tb_scariv_ras_ckpt.sv
// Directed bench for scariv_ras_ckpt at ENTRY_SIZE=4, VADDR_W=39: stack order,
// overflow wrap, push+pop replace, checkpoint restore and reset priority.
module tb_scariv_ras_ckpt;

  localparam int ENTRY_SIZE = 4;
  localparam int VADDR_W    = 39;
  localparam int PTR_W      = 2;
  localparam int CKPT_W     = PTR_W + PTR_W + 1 + VADDR_W;

  logic               clk;
  logic               rst;
  logic               push_valid;
  logic [VADDR_W-1:0] push_vaddr;
  logic               pop_valid;
  logic               restore_valid;
  logic [CKPT_W-1:0]  restore_ckpt;
  logic               top_valid;
  logic [VADDR_W-1:0] top_vaddr;
  logic [CKPT_W-1:0]  ckpt;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [CKPT_W-1:0] saved_ckpt;
  logic [63:0] exp_val;

  scariv_ras_ckpt #(
    .ENTRY_SIZE (ENTRY_SIZE),
    .VADDR_W    (VADDR_W)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_push_valid    (push_valid),
    .i_push_vaddr    (push_vaddr),
    .i_pop_valid     (pop_valid),
    .i_restore_valid (restore_valid),
    .i_restore_ckpt  (restore_ckpt),
    .o_top_valid     (top_valid),
    .o_top_vaddr     (top_vaddr),
    .o_ckpt          (ckpt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CKPT_W-1:0] mk_ckpt(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W:0] c,
                                                input logic [VADDR_W-1:0] t);
    return {p, c, t};
  endfunction

  // driver: apply one cycle of requests, return #1 after the active edge
  task automatic step(input logic push, input logic [VADDR_W-1:0] va, input logic pop,
                      input logic do_rst, input logic rv, input logic [CKPT_W-1:0] ck);
    @(negedge clk);
    push_valid    = push;
    push_vaddr    = va;
    pop_valid     = pop;
    rst           = do_rst;
    restore_valid = rv;
    restore_ckpt  = ck;
    @(posedge clk);
    #1;
    push_valid    = 1'b0;
    push_vaddr    = '0;
    pop_valid     = 1'b0;
    rst           = 1'b0;
    restore_valid = 1'b0;
    restore_ckpt  = '0;
  endtask

  task automatic do_push(input logic [VADDR_W-1:0] va);
    step(1'b1, va, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_pop();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [63:0] top,
                           input logic [63:0] cnt, input logic [63:0] ptr);
    check_val({tag, ".valid"}, 64'(top_valid), 64'(v));
    check_val({tag, ".top"},   64'(top_vaddr), top);
    check_val({tag, ".cnt"},   64'(ckpt[VADDR_W +: PTR_W+1]), cnt);
    check_val({tag, ".ptr"},   64'(ckpt[CKPT_W-1 -: PTR_W]), ptr);
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_vaddr = '0; pop_valid = 1'b0;
    restore_valid = 1'b0; restore_ckpt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state, then idle
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    chk_state("t1_idle", 1'b0, 64'h0, 64'd0, 64'd0);
    check_val("t1_ckpt", 64'(ckpt), 64'h0);

    // 2: LIFO order
    do_push(39'h1000);
    do_push(39'h2000);
    do_push(39'h3000);
    exp_q.push_back(64'h3000);
    exp_q.push_back(64'h2000);
    exp_q.push_back(64'h1000);
    for (int i = 0; i < 3; i++) begin
      exp_val = exp_q.pop_front();
      check_val($sformatf("t2_top%0d", i), 64'(top_vaddr), exp_val);
      check_val($sformatf("t2_cnt%0d", i), 64'(ckpt[VADDR_W +: PTR_W+1]), 64'(3 - i));
      if (i < 2) do_pop();
    end

    // 3: overflow wraps over oldest entry
    do_reset();
    chk_state("t3_rst", 1'b0, 64'h0, 64'd0, 64'd0);
    for (int i = 1; i <= 5; i++) do_push(39'(i * 16));
    chk_state("t3_full", 1'b1, 64'h50, 64'd4, 64'd1);
    exp_q.push_back(64'h50);
    exp_q.push_back(64'h40);
    exp_q.push_back(64'h30);
    exp_q.push_back(64'h20);
    for (int i = 0; i < 4; i++) begin
      exp_val = exp_q.pop_front();
      check_val($sformatf("t3_top%0d", i), 64'(top_vaddr), exp_val);
      do_pop();
    end
    chk_state("t3_empty", 1'b0, 64'h0, 64'd0, 64'd1);
    do_pop();
    chk_state("t3_underflow", 1'b0, 64'h0, 64'd0, 64'd1);

    // 4: push+pop replaces top in place
    do_reset();
    do_push(39'h100);
    do_push(39'h200);
    step(1'b1, 39'h300, 1'b1, 1'b0, 1'b0, '0);
    chk_state("t4_pushpop", 1'b1, 64'h300, 64'd2, 64'd2);
    do_pop();
    chk_state("t4_pop", 1'b1, 64'h100, 64'd1, 64'd1);

    // 5: checkpoint restore after wrong-path pushes/pops
    do_reset();
    do_push(39'h100);
    do_push(39'h200);
    saved_ckpt = ckpt;
    check_val("t5_ckpt", 64'(saved_ckpt), 64'(mk_ckpt(2'd2, 3'd2, 39'h200)));
    do_push(39'hA);
    do_push(39'hB);
    chk_state("t5_wrong", 1'b1, 64'hB, 64'd4, 64'd0);
    repeat (3) do_pop();
    chk_state("t5_popped", 1'b1, 64'h100, 64'd1, 64'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, mk_ckpt(2'd2, 3'd2, 39'h200));
    chk_state("t5_restore", 1'b1, 64'h200, 64'd2, 64'd2);
    do_pop();
    chk_state("t5_after", 1'b1, 64'h100, 64'd1, 64'd1);

    // 6: restore beats push+pop; reset beats push
    do_reset();
    do_push(39'h100);
    do_push(39'h200);
    do_push(39'h777);
    step(1'b1, 39'h999, 1'b1, 1'b0, 1'b1, mk_ckpt(2'd2, 3'd2, 39'h200));
    chk_state("t6_restore", 1'b1, 64'h200, 64'd2, 64'd2);
    do_pop();
    chk_state("t6_pop", 1'b1, 64'h100, 64'd1, 64'd1);
    step(1'b1, 39'h44, 1'b0, 1'b1, 1'b0, '0);
    chk_state("t6_rst_push", 1'b0, 64'h0, 64'd0, 64'd0);
    check_val("t6_ckpt", 64'(ckpt), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
